// File: rtl/intc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intc_pkg
// Brief    : Shared types and helpers for the nested interrupt controller
//            (FSM states, priority encoder, EPC stack entry).
// Revision : 1.0 - initial release
// ============================================================================
package intc_pkg;

  // Ceilings for the package-level types; the controller casts its actual
  // widths into and out of these.
  localparam int MAX_SRC   = 32;
  localparam int ID_MAX_W  = 5;
  localparam int EPC_MAX_W = 64;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] idx;
  } prio_t;

  typedef struct packed {
    logic [EPC_MAX_W-1:0] epc;
    logic [ID_MAX_W-1:0]  id;
  } stack_entry_t;

  // Fixed-priority encoder: lowest set index wins.
  function automatic prio_t prio_enc(input logic [MAX_SRC-1:0] req);
    prio_t r;
    r.valid = 1'b0;
    r.idx   = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        r.valid = 1'b1;
        r.idx   = ID_MAX_W'(i);
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/intc_epc_stack.sv
`default_nettype none
// ============================================================================
// Module   : intc_epc_stack
// Brief    : LIFO of {EPC, source id} entries for nested interrupt return.
//            Top-of-stack is combinational; reset empties the stack.
// Revision : 1.0 - initial release
// ============================================================================
module intc_epc_stack
  import intc_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             in_RST,
  input  logic             push_i,
  input  logic             pop_i,
  input  stack_entry_t     push_data_i,
  output stack_entry_t     top_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  stack_entry_t     mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Push writes the slot at the current count; pop only moves the count.
  always_ff @(posedge clk) begin
    if (!in_RST) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_i && !full_o) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (count_q == CNT_W'(i)) begin
          mem_q[i] <= push_data_i;
        end
      end
      count_q <= count_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Top of stack is the most recently pushed entry; zero when empty.
  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CNT_W'(i + 1)) begin
        top_o = mem_q[i];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/intc_nested.sv
`default_nettype none
// ============================================================================
// Module   : intc_nested
// Brief    : Nested, fixed-priority interrupt controller beside write-back.
//            Edge-latched sources, masking, global enable, DEPTH-level
//            preemption with an EPC/ID stack; redirects PC on entry and eret.
// Revision : 1.0 - initial release
// ============================================================================
module intc_nested
  import intc_pkg::*;
#(
  parameter int                N_SRC      = 4,
  parameter int                DEPTH      = 3,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] VEC_BASE   = ADDR_W'(32'h0000_0400),
  parameter logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(32'h0000_0040)
) (
  input  logic                       clk,
  input  logic                       in_RST,
  input  logic [N_SRC-1:0]           irq_in,
  input  logic [N_SRC-1:0]           irq_mask,
  input  logic                       gie,
  input  logic                       pipe_ready,
  input  logic [ADDR_W-1:0]          wb_pc,
  input  logic                       eret,
  output logic                       take,
  output logic                       ret,
  output logic [ADDR_W-1:0]          force_addr,
  output logic                       active_valid,
  output logic [$clog2(N_SRC)-1:0]   active_id,
  output logic [N_SRC-1:0]           pending,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       underflow_err
);

  localparam int ID_W    = $clog2(N_SRC);
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  state_e              state_q;
  logic [N_SRC-1:0]    irq_q;
  logic [N_SRC-1:0]    pending_q;
  logic [N_SRC-1:0]    pending_d;
  logic                take_q;
  logic                ret_q;
  logic                underflow_q;
  logic [ADDR_W-1:0]   force_addr_q;

  logic [N_SRC-1:0]    irq_edge;
  logic [N_SRC-1:0]    eligible;
  logic [N_SRC-1:0]    clr;
  prio_t               enc;
  logic [ID_W-1:0]     cand_id;
  logic                cand_ok;
  logic                do_take;
  logic                do_pop;
  logic [ADDR_W-1:0]   vector;
  logic [ADDR_W-1:0]   top_epc;
  logic [ID_W-1:0]     top_id;

  stack_entry_t        push_entry;
  stack_entry_t        top_entry;
  logic                stk_full;
  logic                stk_empty;
  logic [DEPTH_W-1:0]  stk_count;

  // Upper bits of the package-wide types beyond this instance's widths.
  logic                unused_bits;
  assign unused_bits = ^{enc.idx, top_entry};

  intc_epc_stack #(
    .DEPTH (DEPTH),
    .CNT_W (DEPTH_W)
  ) u_stack (
    .clk         (clk),
    .in_RST      (in_RST),
    .push_i      (do_take),
    .pop_i       (do_pop),
    .push_data_i (push_entry),
    .top_o       (top_entry),
    .full_o      (stk_full),
    .empty_o     (stk_empty),
    .count_o     (stk_count)
  );

  // Arbitration: pick the best eligible source and decide take/pop this cycle.
  always_comb begin
    irq_edge = irq_in & ~irq_q;
    eligible = gie ? (pending_q & ~irq_mask) : '0;
    enc      = prio_enc(MAX_SRC'(eligible));
    cand_id  = ID_W'(enc.idx);
    top_id   = ID_W'(top_entry.id);
    top_epc  = ADDR_W'(top_entry.epc);
    // Preempt only a strictly lower-priority handler, and only with room left.
    cand_ok  = enc.valid && !stk_full && (stk_empty || (cand_id < top_id));
    // eret has precedence over a new entry in the same cycle.
    do_pop   = (state_q == RUN) && eret && !stk_empty;
    do_take  = (state_q == RUN) && !eret && cand_ok && pipe_ready;
    vector   = VEC_BASE + (ADDR_W'(cand_id) * VEC_STRIDE);
    clr      = do_take ? (N_SRC'(1) << cand_id) : '0;
    // A fresh edge on the bit being serviced is retained (set after clear).
    pending_d = (pending_q & ~clr) | irq_edge;
    push_entry.epc = EPC_MAX_W'(wb_pc);
    push_entry.id  = ID_MAX_W'(cand_id);
  end

  // Edge detector and pending latch.
  always_ff @(posedge clk) begin
    if (!in_RST) begin
      irq_q     <= '0;
      pending_q <= '0;
    end else begin
      irq_q     <= irq_in;
      pending_q <= pending_d;
    end
  end

  // Redirect FSM: one-cycle take/ret pulses, then a refill cycle in WAIT.
  always_ff @(posedge clk) begin
    if (!in_RST) begin
      state_q      <= RUN;
      take_q       <= 1'b0;
      ret_q        <= 1'b0;
      force_addr_q <= '0;
      underflow_q  <= 1'b0;
    end else begin
      take_q <= 1'b0;
      ret_q  <= 1'b0;
      case (state_q)
        RUN: begin
          if (eret) begin
            if (!stk_empty) begin
              ret_q        <= 1'b1;
              force_addr_q <= top_epc;
              state_q      <= WAIT;
            end else begin
              underflow_q  <= 1'b1;
            end
          end else if (cand_ok && pipe_ready) begin
            take_q       <= 1'b1;
            force_addr_q <= vector;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          state_q <= RUN;
        end
        default: begin
          state_q <= RUN;
        end
      endcase
    end
  end

  assign take          = take_q;
  assign ret           = ret_q;
  assign force_addr    = force_addr_q;
  assign pending       = pending_q;
  assign depth         = stk_count;
  assign active_valid  = !stk_empty;
  assign active_id     = top_id;
  assign underflow_err = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_intc_nested.sv
`default_nettype none
// ============================================================================
// Module   : tb_intc_nested
// Brief    : Directed self-checking bench for intc_nested with a redirect
//            scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_intc_nested;

  logic        clk = 1'b0;
  logic        in_RST;
  logic [3:0]  irq_in;
  logic [3:0]  irq_mask;
  logic        gie;
  logic        pipe_ready;
  logic [31:0] wb_pc;
  logic        eret;
  logic        take;
  logic        ret;
  logic [31:0] force_addr;
  logic        active_valid;
  logic [1:0]  active_id;
  logic [3:0]  pending;
  logic [1:0]  depth;
  logic        underflow_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit          is_ret;
    logic [31:0] addr;
    logic [1:0]  dep;
    logic [1:0]  id;
  } exp_t;

  exp_t sb[$];

  intc_nested dut (
    .clk           (clk),
    .in_RST        (in_RST),
    .irq_in        (irq_in),
    .irq_mask      (irq_mask),
    .gie           (gie),
    .pipe_ready    (pipe_ready),
    .wb_pc         (wb_pc),
    .eret          (eret),
    .take          (take),
    .ret           (ret),
    .force_addr    (force_addr),
    .active_valid  (active_valid),
    .active_id     (active_id),
    .pending       (pending),
    .depth         (depth),
    .underflow_err (underflow_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input bit is_ret, input logic [31:0] addr,
                          input logic [1:0] dep, input logic [1:0] id);
    exp_t e;
    e.is_ret = is_ret;
    e.addr   = addr;
    e.dep    = dep;
    e.id     = id;
    sb.push_back(e);
  endtask

  task automatic check_redirect(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=redirect expected=no_entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".take"}, {31'b0, take}, {31'b0, ~e.is_ret});
      chk({tag, ".ret"},  {31'b0, ret},  {31'b0, e.is_ret});
      chk({tag, ".addr"}, force_addr, e.addr);
      chk({tag, ".depth"}, {30'b0, depth}, {30'b0, e.dep});
      chk({tag, ".id"}, {30'b0, active_id}, {30'b0, e.id});
    end
  endtask

  task automatic wait_redirect(input string tag, input int bound);
    int   n;
    exp_t e;
    n = 0;
    do begin
      step();
      n++;
    end while (!(take || ret) && n < bound);
    if (!(take || ret)) begin
      checks++;
      failures++;
      $error("FAIL %s observed=no_redirect expected=redirect", tag);
      if (sb.size() > 0) e = sb.pop_front();
    end else begin
      check_redirect(tag);
    end
  endtask

  initial begin
    in_RST = 1'b0; irq_in = '0; irq_mask = '0; gie = 1'b0;
    pipe_ready = 1'b0; wb_pc = '0; eret = 1'b0;
    step(); step();
    chk("rst.take", {31'b0, take}, 32'd0);
    chk("rst.ret", {31'b0, ret}, 32'd0);
    chk("rst.force_addr", force_addr, 32'd0);
    chk("rst.pending", {28'b0, pending}, 32'd0);
    chk("rst.depth", {30'b0, depth}, 32'd0);
    chk("rst.active_valid", {31'b0, active_valid}, 32'd0);
    chk("rst.active_id", {30'b0, active_id}, 32'd0);
    chk("rst.underflow", {31'b0, underflow_err}, 32'd0);
    in_RST = 1'b1; gie = 1'b1; pipe_ready = 1'b1;
    step();

    // Single request on source 2
    wb_pc = 32'h100; irq_in = 4'b0100; push_exp(0, 32'h480, 2'd1, 2'd2);
    step();
    chk("t1.pending", {28'b0, pending}, 32'h4);
    chk("t1.early_take", {31'b0, take}, 32'd0);
    step();
    check_redirect("t1.take");
    chk("t1.pending_clr", {28'b0, pending}, 32'h0);
    chk("t1.active_valid", {31'b0, active_valid}, 32'd1);
    irq_in = 4'b0000;
    step();
    chk("t1.take_pulse", {31'b0, take}, 32'd0);
    eret = 1'b1; push_exp(1, 32'h100, 2'd0, 2'd0);
    step();
    check_redirect("t1.ret");
    eret = 1'b0;
    chk("t1.idle", {31'b0, active_valid}, 32'd0);
    step();

    // Nesting: 0 preempts 2
    wb_pc = 32'h100; irq_in = 4'b0100; push_exp(0, 32'h480, 2'd1, 2'd2);
    wait_redirect("t2.take2", 6); irq_in = 4'b0000; step();
    wb_pc = 32'h490; irq_in = 4'b0001; push_exp(0, 32'h400, 2'd2, 2'd0);
    wait_redirect("t2.take0", 6); irq_in = 4'b0000; step();
    eret = 1'b1; push_exp(1, 32'h490, 2'd1, 2'd2);
    wait_redirect("t2.ret1", 4); eret = 1'b0; step();
    eret = 1'b1; push_exp(1, 32'h100, 2'd0, 2'd0);
    wait_redirect("t2.ret0", 4); eret = 1'b0; step();

    // Lower priority does not preempt
    wb_pc = 32'h200; irq_in = 4'b0010; push_exp(0, 32'h440, 2'd1, 2'd1);
    wait_redirect("t3.take1", 6); irq_in = 4'b0000; step();
    irq_in = 4'b1000;
    step(); step(); step();
    chk("t3.no_take", {31'b0, take}, 32'd0);
    chk("t3.pending3", {28'b0, pending}, 32'h8);
    chk("t3.depth", {30'b0, depth}, 32'd1);
    irq_in = 4'b0000;
    eret = 1'b1; push_exp(1, 32'h200, 2'd0, 2'd0);
    step();
    check_redirect("t3.ret");
    eret = 1'b0; wb_pc = 32'h300; push_exp(0, 32'h4C0, 2'd1, 2'd3);
    step();
    chk("t3.gap", {31'b0, take}, 32'd0);
    step();
    check_redirect("t3.take3");
    step();
    eret = 1'b1; push_exp(1, 32'h300, 2'd0, 2'd0);
    wait_redirect("t3.ret3", 4); eret = 1'b0; step();

    // Masking
    irq_mask = 4'b0010; irq_in = 4'b0010;
    step(); step(); step();
    chk("t4.masked_take", {31'b0, take}, 32'd0);
    chk("t4.masked_pending", {28'b0, pending}, 32'h2);
    irq_in = 4'b0000; irq_mask = 4'b0000; wb_pc = 32'h500;
    push_exp(0, 32'h440, 2'd1, 2'd1);
    wait_redirect("t4.unmask", 4); step();
    chk("t4.pending_clr", {28'b0, pending}, 32'h0);
    eret = 1'b1; push_exp(1, 32'h500, 2'd0, 2'd0);
    wait_redirect("t4.ret_m", 4); eret = 1'b0; step();

    // Stack full: 3 -> 2 -> 1, then 0 held
    wb_pc = 32'h600; irq_in = 4'b1000; push_exp(0, 32'h4C0, 2'd1, 2'd3);
    wait_redirect("t4.l1", 6); irq_in = 4'b0000; step();
    wb_pc = 32'h610; irq_in = 4'b0100; push_exp(0, 32'h480, 2'd2, 2'd2);
    wait_redirect("t4.l2", 6); irq_in = 4'b0000; step();
    wb_pc = 32'h620; irq_in = 4'b0010; push_exp(0, 32'h440, 2'd3, 2'd1);
    wait_redirect("t4.l3", 6); irq_in = 4'b0000; step();
    wb_pc = 32'h630; irq_in = 4'b0001;
    step(); step(); step();
    chk("t4.full_no_take", {31'b0, take}, 32'd0);
    chk("t4.full_pending", {28'b0, pending}, 32'h1);
    chk("t4.full_depth", {30'b0, depth}, 32'd3);
    irq_in = 4'b0000;
    eret = 1'b1; push_exp(1, 32'h620, 2'd2, 2'd2);
    step();
    check_redirect("t4.ret_l3");
    eret = 1'b0; push_exp(0, 32'h400, 2'd3, 2'd0);
    step();
    chk("t4.held_gap", {31'b0, take}, 32'd0);
    step();
    check_redirect("t4.held_take");
    step();
    eret = 1'b1; push_exp(1, 32'h630, 2'd2, 2'd2);
    wait_redirect("t4.r3", 4); eret = 1'b0; step();
    eret = 1'b1; push_exp(1, 32'h610, 2'd1, 2'd3);
    wait_redirect("t4.r2", 4); eret = 1'b0; step();
    eret = 1'b1; push_exp(1, 32'h600, 2'd0, 2'd0);
    wait_redirect("t4.r1", 4); eret = 1'b0; step();

    // eret and new edge in the same cycle
    wb_pc = 32'h700; irq_in = 4'b0100; push_exp(0, 32'h480, 2'd1, 2'd2);
    wait_redirect("t5.take2", 6); irq_in = 4'b0000; step();
    eret = 1'b1; irq_in = 4'b0010; wb_pc = 32'h710;
    push_exp(1, 32'h700, 2'd0, 2'd0);
    push_exp(0, 32'h440, 2'd1, 2'd1);
    step();
    check_redirect("t5.ret_first");
    eret = 1'b0; irq_in = 4'b0000;
    step();
    chk("t5.gap", {31'b0, take}, 32'd0);
    chk("t5.pending", {28'b0, pending}, 32'h2);
    step();
    check_redirect("t5.take_after");
    step();
    eret = 1'b1; push_exp(1, 32'h710, 2'd0, 2'd0);
    wait_redirect("t5.ret1", 4); eret = 1'b0; step();

    // eret at depth 0
    eret = 1'b1;
    step();
    chk("t5.underflow", {31'b0, underflow_err}, 32'd1);
    chk("t5.underflow_no_ret", {31'b0, ret}, 32'd0);
    eret = 1'b0;
    step();
    chk("t5.underflow_sticky", {31'b0, underflow_err}, 32'd1);

    // Reset mid-handler
    wb_pc = 32'h800; irq_in = 4'b1000; push_exp(0, 32'h4C0, 2'd1, 2'd3);
    wait_redirect("t6.take3", 6);
    irq_mask = 4'b0100; irq_in = 4'b1100;
    step(); step();
    chk("t6.pending", {28'b0, pending}, 32'h4);
    chk("t6.depth", {30'b0, depth}, 32'd1);
    in_RST = 1'b0; irq_in = 4'b0000;
    step();
    chk("t6.depth_rst", {30'b0, depth}, 32'd0);
    chk("t6.valid_rst", {31'b0, active_valid}, 32'd0);
    chk("t6.pending_rst", {28'b0, pending}, 32'h0);
    chk("t6.take_rst", {31'b0, take}, 32'd0);
    chk("t6.ret_rst", {31'b0, ret}, 32'd0);
    chk("t6.addr_rst", force_addr, 32'd0);
    chk("t6.underflow_rst", {31'b0, underflow_err}, 32'd0);
    in_RST = 1'b1; irq_mask = 4'b0000;
    step(); step(); step();
    chk("t6.quiet", {31'b0, take | ret}, 32'd0);
    chk("t6.depth_after", {30'b0, depth}, 32'd0);
    chk("sb.drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/intc_nested.md
# intc_nested

Parametrised nested-interrupt controller for the five-stage pipeline. It replaces the fixed four-input interrupt/EPC logic and supports N_SRC edge-triggered sources with fixed priority, per-source masking and a global enable. Preemption is nested up to DEPTH levels, with return addresses held in an internal EPC/ID stack. It sits beside the write-back stage: it issues a one-cycle redirect (pipeline flush plus forced PC) on interrupt entry and on eret.

## Interface
- N_SRC, 4: number of interrupt sources; index 0 is the highest priority.
- DEPTH, 3: maximum nesting depth (EPC stack entries).
- ADDR_W, 32: PC width.
- VEC_BASE, 32'h0000_0400: handler address of source 0.
- VEC_STRIDE, 32'h0000_0040: handler spacing; source i vectors to VEC_BASE + i*VEC_STRIDE.
- clk  in  1  single clock, all state on rising edge.
- in_RST  in  1  reset; synchronous, active-low.
- irq_in  in  N_SRC  raw interrupt lines; rising edge requests.
- irq_mask  in  N_SRC  1 = source masked (stays pending, not eligible).
- gie  in  1  global interrupt enable.
- pipe_ready  in  1  WB holds a retiring, unlocked instruction; a redirect may be taken.
- wb_pc  in  ADDR_W  resume address (PC of next instruction after WB).
- eret  in  1  eret retiring in WB this cycle.
- take  out  1  one-cycle pulse: flush IF..MEM, load force_addr into PC.
- ret  out  1  one-cycle pulse: eret redirect, load force_addr into PC.
- force_addr  out  ADDR_W  target PC, valid while take or ret.
- active_valid  out  1  a handler is in service (depth > 0).
- active_id  out  $clog2(N_SRC)  source being serviced (top of stack).
- pending  out  N_SRC  latched requests.
- depth  out  $clog2(DEPTH+1)  current nesting level.
- underflow_err  out  1  sticky: eret received with depth 0.

## Operation
- Edge detect: irq_q <= irq_in each cycle. An edge is irq_in & ~irq_q, and it sets the matching pending bit.
- Eligible = pending & ~irq_mask when gie = 1; all zero otherwise. Candidate = lowest eligible index.
- Preemption: a candidate is taken only if depth < DEPTH, and either depth == 0 or candidate index < active_id (strictly higher priority).
- FSM states: RUN, WAIT.
  - RUN, eret = 1 and depth > 0: pop the stack, pulse ret with force_addr = popped EPC, go to WAIT.
  - RUN, eret = 1 and depth == 0: set underflow_err, no pulse, stay in RUN.
  - RUN, no eret, candidate allowed and pipe_ready: push {wb_pc, candidate}, clear pending[candidate], pulse take with force_addr = vector, go to WAIT.
  - RUN, otherwise: stay in RUN.
  - WAIT: one cycle with no arbitration and eret ignored (pipeline refill), then go to RUN.
- eret and an eligible request in the same cycle: eret wins. The request stays pending and is re-arbitrated against the restored level.
- Edge and clear for the same bit in the same cycle: set wins, so the new request is retained.
- Stack full (depth == DEPTH): requests stay pending and are serviced after the next ret.
- While take and ret are low, force_addr holds its last value. Consumers qualify it with take or ret.

## Timing
- Reset values (in_RST low at a clock edge): take = 0, ret = 0, force_addr = 0, pending = 0, irq_q = 0, depth = 0, active_valid = 0, active_id = 0, underflow_err = 0, state = RUN.
- Reset asserted mid-handler discards the stack; no ret is generated.
- Latency, with an irq_in edge first sampled at edge t:
  - pending visible after t+1;
  - take high during cycle t+2 at the earliest (gie set, unmasked, pipe_ready);
  - depth and active_id update on the same edge that raises take.
- eret sampled at edge t gives ret high during the following cycle; depth and active_id update on that edge.
- Minimum spacing between any two redirect pulses is 2 cycles, set by WAIT.
- take and ret are never high together.

## Structure
- Package intc_pkg holds:
  - the state enum {RUN, WAIT};
  - function prio_enc(N_SRC) returning {valid, index};
  - the stack entry typedef {epc[ADDR_W], id}.
- Sub-module intc_epc_stack: push/pop LIFO with DEPTH entries, top-of-stack output, full/empty flags. Synchronous active-low reset empties it.

## Test plan
- Single request: raise irq_in[2] with gie = 1, mask = 0, wb_pc = 0x100. Expect take two cycles later, force_addr = 0x480, depth = 1, active_id = 2, pending[2] = 0. Then eret gives ret with force_addr = 0x100 and depth = 0.
- Nesting: while servicing source 2, raise irq_in[0] with wb_pc = 0x490. Expect take with force_addr = 0x400 and depth = 2. Two erets return to 0x490 and then to the original resume address.
- No preemption by equal or lower priority: while servicing source 1, raise irq_in[3]. Expect no take and pending[3] = 1. Source 3 is taken two cycles after the ret.
- Masking and stack full: with mask[1] = 1, irq 1 stays pending with no take; clearing the mask gives take. With DEPTH = 3 and three nested levels, a fourth higher-priority request is held.
- Boundary events: eret and a new edge in the same cycle give ret first, then take two cycles later. eret at depth 0 sets underflow_err. in_RST low mid-handler clears depth, pending and outputs on the next edge.
